// File: rtl/alu_muldiv_if.sv
// Bus bundle between the execute stage and alu_muldiv: ALU operands/result
// plus the multiply/divide start/busy handshake and the HI/LO registers.
interface alu_muldiv_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic [WIDTH-1:0]   busA;
  logic [WIDTH-1:0]   busB;
  logic [3:0]         ALUop;
  logic [SHAMT_W-1:0] s;
  logic [WIDTH-1:0]   ALUout;
  logic               ovf;
  logic [2:0]         md_op;
  logic               md_start;
  logic               md_cancel;
  logic               md_busy;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (
    output busA, busB, ALUop, s, md_op, md_start, md_cancel,
    input  ALUout, ovf, md_busy, hi, lo
  );

  modport slave (
    input  busA, busB, ALUop, s, md_op, md_start, md_cancel,
    output ALUout, ovf, md_busy, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// Execute-stage ALU (combinational) plus a multi-cycle multiply/divide unit
// with architectural HI/LO, start/busy handshake and flush cancel.
module alu_muldiv #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned MUL_LAT = 3
) (
  input logic          clk,
  input logic          rst,
  alu_muldiv_if.slave  bus
);

  localparam int unsigned MSB   = WIDTH - 1;
  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // ---------------- ALU path ----------------
  logic [WIDTH-1:0]   alu_a, alu_b, sum, diff, alu_out;
  logic [SHAMT_W-1:0] vsh;
  logic               alu_ovf;

  assign alu_a = bus.busA;
  assign alu_b = bus.busB;
  assign sum   = alu_a + alu_b;
  assign diff  = alu_a - alu_b;
  assign vsh   = alu_a[SHAMT_W-1:0];

  always_comb begin
    alu_out = '0;
    alu_ovf = 1'b0;
    case (bus.ALUop)
      4'd0: begin
        alu_out = sum;
        alu_ovf = (alu_a[MSB] == alu_b[MSB]) && (sum[MSB] != alu_a[MSB]);
      end
      4'd1: begin
        alu_out = diff;
        alu_ovf = (alu_a[MSB] != alu_b[MSB]) && (diff[MSB] != alu_a[MSB]);
      end
      4'd2:    alu_out = alu_a | alu_b;
      4'd3:    alu_out = alu_a & alu_b;
      4'd4:    alu_out = ~(alu_a | alu_b);
      4'd5:    alu_out = alu_b << bus.s;
      4'd6:    alu_out = alu_b >> bus.s;
      4'd7:    alu_out = WIDTH'($signed(alu_b) >>> bus.s);
      4'd8:    alu_out = WIDTH'($signed(alu_a) < $signed(alu_b));
      4'd9:    alu_out = WIDTH'(alu_a < alu_b);
      4'd10:   alu_out = alu_a ^ alu_b;
      4'd11:   alu_out = alu_b << vsh;
      4'd12:   alu_out = alu_b >> vsh;
      4'd13:   alu_out = WIDTH'($signed(alu_b) >>> vsh);
      4'd14:   alu_out = alu_b << HALF;
      default: alu_out = '0;
    endcase
  end

  assign bus.ALUout = alu_out;
  assign bus.ovf    = alu_ovf;

  // ---------------- MDU state ----------------
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] op_a, op_a_nxt, op_b, op_b_nxt;
  logic             is_signed, is_signed_nxt;
  logic [WIDTH-1:0] rem, rem_nxt, quo, quo_nxt, dvs, dvs_nxt;
  logic [WIDTH-1:0] hi_q, hi_nxt, lo_q, lo_nxt;
  logic             busy_q;

  // Full-width product from latched operands; extension picks signed/unsigned
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  assign ext_a = is_signed ? {{WIDTH{op_a[MSB]}}, op_a} : {{WIDTH{1'b0}}, op_a};
  assign ext_b = is_signed ? {{WIDTH{op_b[MSB]}}, op_b} : {{WIDTH{1'b0}}, op_b};
  assign prod  = ext_a * ext_b;

  // One restoring step: shift in next dividend bit, subtract if it fits
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step, quo_step, q_fin, r_fin;
  logic             q_neg, r_neg;

  always_comb begin
    trial = {rem, quo[MSB]} - {1'b0, dvs};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo[MSB-1:0], 1'b1};
    end else begin
      rem_step = {rem[MSB-1:0], quo[MSB]};
      quo_step = {quo[MSB-1:0], 1'b0};
    end
  end

  assign q_neg = is_signed & (op_a[MSB] ^ op_b[MSB]);
  assign r_neg = is_signed & op_a[MSB];
  assign q_fin = q_neg ? -quo_step : quo_step;
  assign r_fin = r_neg ? -rem_step : rem_step;

  // Operand magnitudes for a divide launched this cycle
  logic             start_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign start_signed = (bus.md_op == OP_DIV);
  assign mag_a = (start_signed && alu_a[MSB]) ? -alu_a : alu_a;
  assign mag_b = (start_signed && alu_b[MSB]) ? -alu_b : alu_b;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    op_a_nxt      = op_a;
    op_b_nxt      = op_b;
    is_signed_nxt = is_signed;
    rem_nxt       = rem;
    quo_nxt       = quo;
    dvs_nxt       = dvs;
    hi_nxt        = hi_q;
    lo_nxt        = lo_q;
    case (state)
      IDLE: begin
        if (bus.md_start && !bus.md_cancel) begin
          case (bus.md_op)
            OP_MULT, OP_MULTU: begin
              op_a_nxt      = alu_a;
              op_b_nxt      = alu_b;
              is_signed_nxt = (bus.md_op == OP_MULT);
              cnt_nxt       = CNT_W'(MUL_LAT - 1);
              state_nxt     = MUL;
            end
            OP_DIV, OP_DIVU: begin
              op_a_nxt      = alu_a;
              op_b_nxt      = alu_b;
              is_signed_nxt = start_signed;
              rem_nxt       = '0;
              quo_nxt       = mag_a;
              dvs_nxt       = mag_b;
              cnt_nxt       = CNT_W'(WIDTH - 1);
              state_nxt     = DIV;
            end
            OP_MTHI: hi_nxt = alu_a;
            OP_MTLO: lo_nxt = alu_a;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (bus.md_cancel) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          {hi_nxt, lo_nxt} = prod;
          state_nxt        = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DIV: begin
        if (bus.md_cancel) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
          if (op_b == '0) begin
            lo_nxt = '1;
            hi_nxt = op_a;
          end else begin
            lo_nxt = q_fin;
            hi_nxt = r_fin;
          end
        end else begin
          rem_nxt = rem_step;
          quo_nxt = quo_step;
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      is_signed <= 1'b0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      is_signed <= is_signed_nxt;
      rem       <= rem_nxt;
      quo       <= quo_nxt;
      dvs       <= dvs_nxt;
      hi_q      <= hi_nxt;
      lo_q      <= lo_nxt;
      busy_q    <= (state_nxt != IDLE);
    end
  end

  assign bus.md_busy = busy_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule
